// File: rtl/int_controller.sv
// Prioritised interrupt controller: captures rising edges on the peripheral
// request lines, applies a per-source mask and a global enable, and presents
// one request at a time to the cpu, together with that source's vector.
// The handshake is request, acknowledge, return, and handlers never nest.
module int_controller #(
  parameter int          NUM_SRC    = 4,
  parameter logic [15:0] VEC_BASE   = 16'h0010,
  parameter logic [15:0] VEC_STRIDE = 16'h0004
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               sel,
  input  logic [1:0]         addr,
  input  logic               write,
  input  logic               read,
  input  logic [15:0]        wdata,
  output logic [15:0]        rdata,
  output logic               int_req,
  output logic [15:0]        int_vector,
  input  logic               int_ack,
  input  logic               int_done,
  output logic [3:0]         active_id
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd1;
  localparam logic [1:0] ADDR_CTRL    = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  state_t             state, state_next;
  logic [NUM_SRC-1:0] irq_q, pending, mask;
  logic [NUM_SRC-1:0] rise, w1c, act_oh, ack_clr, pending_next, eligible;
  logic               gie, gie_next;
  logic               wr_en, rd_en;
  logic               win_valid, load_grant;
  logic [3:0]         win_id;
  logic [15:0]        win_vector, rd_mux;

  // Wide write data is only partly used when NUM_SRC is small.
  logic unused_wdata;
  assign unused_wdata = ^wdata;

  // Bus decode, edge detection and the next value of the pending register.
  // NOTE: every combinational output is given a default before any branch,
  // so no path can leave a value unassigned and infer a latch.
  always_comb begin
    wr_en    = sel & write;
    rd_en    = sel & read;
    rise     = irq_src & ~irq_q;
    w1c      = (wr_en && addr == ADDR_PENDING) ? wdata[NUM_SRC-1:0] : '0;
    gie_next = (wr_en && addr == ADDR_CTRL) ? wdata[0] : gie;
    act_oh   = '0;
    for (int i = 0; i < NUM_SRC; i++) act_oh[i] = (active_id == 4'(i));
    ack_clr  = (state == REQ && int_ack) ? act_oh : '0;
    // A new edge on a bit being cleared in the same cycle keeps the bit set.
    pending_next = (pending & ~w1c & ~ack_clr) | rise;
    eligible     = gie ? (pending & mask) : '0;
  end

  // Fixed priority: the lowest eligible index wins.
  always_comb begin
    win_valid = |eligible;
    win_id    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = 4'(i);
    end
    win_vector = VEC_BASE + {12'b0, win_id} * VEC_STRIDE;
  end

  // Handshake sequencing: next state and grant strobe.
  always_comb begin
    state_next = state;
    load_grant = 1'b0;
    case (state)
      IDLE: begin
        if (win_valid) begin
          state_next = REQ;
          load_grant = 1'b1;
        end
      end
      REQ: begin
        // An ack takes precedence over a withdrawal in the same cycle.
        if (int_ack) state_next = SERVICE;
        else if (!gie_next || !(|(pending_next & act_oh))) state_next = IDLE;
      end
      SERVICE: begin
        if (int_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Register read multiplexer; unimplemented bits read as zero.
  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_PENDING: rd_mux = 16'(pending);
      ADDR_MASK:    rd_mux = 16'(mask);
      ADDR_CTRL:    rd_mux = {15'b0, gie};
      ADDR_STATUS:  rd_mux = {state == SERVICE, state == REQ, 10'b0, active_id};
      default:      rd_mux = '0;
    endcase
  end

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the values from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Edge history, register file, read data and the latched grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q      <= '0;
      pending    <= '0;
      mask       <= '0;
      gie        <= 1'b0;
      rdata      <= '0;
      active_id  <= '0;
      int_vector <= '0;
    end else begin
      irq_q   <= irq_src;
      pending <= pending_next;
      gie     <= gie_next;
      if (wr_en && addr == ADDR_MASK) mask <= wdata[NUM_SRC-1:0];
      if (rd_en) rdata <= rd_mux;
      if (load_grant) begin
        active_id  <= win_id;
        int_vector <= win_vector;
      end
    end
  end

  assign int_req = (state == REQ);

endmodule

// File: tb/tb_int_controller.sv
// Self-checking bench for int_controller: directed scenarios followed by a
// randomized run compared against a cycle-level behavioural model.
module tb_int_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq_src;
  logic        sel, write, read;
  logic [1:0]  addr;
  logic [15:0] wdata, rdata;
  logic        int_req;
  logic [15:0] int_vector;
  logic        int_ack, int_done;
  logic [3:0]  active_id;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  int_controller #(.NUM_SRC(4), .VEC_BASE(16'h0010), .VEC_STRIDE(16'h0004)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .sel(sel), .addr(addr),
    .write(write), .read(read), .wdata(wdata), .rdata(rdata),
    .int_req(int_req), .int_vector(int_vector), .int_ack(int_ack),
    .int_done(int_done), .active_id(active_id)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    sel = 1'b1; write = 1'b1; addr = a; wdata = d;
    tick();
    sel = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
    sel = 1'b1; read = 1'b1; addr = a;
    tick();
    sel = 1'b0; read = 1'b0;
    d = rdata;
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
  endtask

  task automatic pulse_done();
    int_done = 1'b1; tick(); int_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    irq_src = '0; sel = 0; write = 0; read = 0; addr = '0; wdata = '0;
    int_ack = 0; int_done = 0; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_checks++; if (int_req !== 1'b0) $display("FAIL reset_req: got %b want 0", int_req); else n_pass++;
    n_checks++; if (int_vector !== 16'h0) $display("FAIL reset_vec: got %h want 0000", int_vector); else n_pass++;
    n_checks++; if (active_id !== 4'h0) $display("FAIL reset_id: got %h want 0", active_id); else n_pass++;
    n_checks++; if (rdata !== 16'h0) $display("FAIL reset_rdata: got %h want 0000", rdata); else n_pass++;
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), d);
      n_checks++; if (d !== 16'h0) $display("FAIL reset_reg%0d: got %h want 0000", a, d); else n_pass++;
    end
  endtask

  task automatic test_basic();
    logic [15:0] d;
    bus_write(2'd1, 16'h0001);
    bus_write(2'd2, 16'h0001);
    irq_src = 4'b0001; tick(); irq_src = '0;
    n_checks++; if (int_req !== 1'b0) $display("FAIL basic_early: got %b want 0", int_req); else n_pass++;
    tick();
    n_checks++; if (int_req !== 1'b1) $display("FAIL basic_req: got %b want 1", int_req); else n_pass++;
    n_checks++; if (int_vector !== 16'h0010) $display("FAIL basic_vec: got %h want 0010", int_vector); else n_pass++;
    pulse_ack();
    n_checks++; if (int_req !== 1'b0) $display("FAIL basic_ack: got %b want 0", int_req); else n_pass++;
    bus_read(2'd0, d);
    n_checks++; if (d !== 16'h0000) $display("FAIL basic_pend: got %h want 0000", d); else n_pass++;
    bus_read(2'd3, d);
    n_checks++; if (d !== 16'h8000) $display("FAIL basic_status_svc: got %h want 8000", d); else n_pass++;
    pulse_done();
    bus_read(2'd3, d);
    n_checks++; if (d !== 16'h0000) $display("FAIL basic_status_idle: got %h want 0000", d); else n_pass++;
  endtask

  task automatic test_priority();
    bus_write(2'd1, 16'h000F);
    irq_src = 4'b1010; tick(); irq_src = '0;
    tick();
    n_checks++; if (int_req !== 1'b1) $display("FAIL prio_req1: got %b want 1", int_req); else n_pass++;
    n_checks++; if (active_id !== 4'd1) $display("FAIL prio_id1: got %0d want 1", active_id); else n_pass++;
    n_checks++; if (int_vector !== 16'h0014) $display("FAIL prio_vec1: got %h want 0014", int_vector); else n_pass++;
    pulse_ack();
    pulse_done();
    n_checks++; if (int_req !== 1'b0) $display("FAIL prio_gap: got %b want 0", int_req); else n_pass++;
    tick();
    n_checks++; if (int_req !== 1'b1) $display("FAIL prio_req2: got %b want 1", int_req); else n_pass++;
    n_checks++; if (active_id !== 4'd3) $display("FAIL prio_id2: got %0d want 3", active_id); else n_pass++;
    n_checks++; if (int_vector !== 16'h001C) $display("FAIL prio_vec2: got %h want 001c", int_vector); else n_pass++;
    pulse_ack();
    pulse_done();
  endtask

  task automatic test_masking();
    logic [15:0] d;
    bus_write(2'd1, 16'h0000);
    irq_src = 4'b0100; tick(); irq_src = '0;
    tick(); tick();
    n_checks++; if (int_req !== 1'b0) $display("FAIL mask_noreq: got %b want 0", int_req); else n_pass++;
    bus_read(2'd0, d);
    n_checks++; if (d !== 16'h0004) $display("FAIL mask_pend: got %h want 0004", d); else n_pass++;
    bus_write(2'd1, 16'h0004);
    tick();
    n_checks++; if (int_req !== 1'b1) $display("FAIL mask_req: got %b want 1", int_req); else n_pass++;
    n_checks++; if (int_vector !== 16'h0018) $display("FAIL mask_vec: got %h want 0018", int_vector); else n_pass++;
    pulse_ack();
    pulse_done();
  endtask

  task automatic test_withdraw();
    logic [15:0] d;
    bus_write(2'd1, 16'h0001);
    irq_src = 4'b0001; tick(); irq_src = '0;
    tick();
    n_checks++; if (int_req !== 1'b1) $display("FAIL wd_req: got %b want 1", int_req); else n_pass++;
    bus_write(2'd2, 16'h0000);
    n_checks++; if (int_req !== 1'b0) $display("FAIL wd_drop: got %b want 0", int_req); else n_pass++;
    bus_read(2'd0, d);
    n_checks++; if (d !== 16'h0001) $display("FAIL wd_pend: got %h want 0001", d); else n_pass++;
    bus_write(2'd2, 16'h0001);
    tick();
    n_checks++; if (int_req !== 1'b1) $display("FAIL wd_reissue: got %b want 1", int_req); else n_pass++;
    n_checks++; if (int_vector !== 16'h0010) $display("FAIL wd_vec: got %h want 0010", int_vector); else n_pass++;
    pulse_ack();
    pulse_done();
  endtask

  task automatic test_level_w1c();
    logic [15:0] d;
    bus_write(2'd2, 16'h0000);
    irq_src = 4'b0001;
    repeat (10) tick();
    bus_read(2'd0, d);
    n_checks++; if (d !== 16'h0001) $display("FAIL level_once: got %h want 0001", d); else n_pass++;
    bus_write(2'd0, 16'h0001);
    bus_read(2'd0, d);
    n_checks++; if (d !== 16'h0000) $display("FAIL level_noreset: got %h want 0000", d); else n_pass++;
    irq_src = '0; tick();
    irq_src = 4'b0010;
    bus_write(2'd0, 16'h0002);
    bus_read(2'd0, d);
    n_checks++; if (d !== 16'h0002) $display("FAIL w1c_race: got %h want 0002", d); else n_pass++;
    irq_src = '0;
    bus_write(2'd0, 16'h000F);
    bus_read(2'd0, d);
    n_checks++; if (d !== 16'h0000) $display("FAIL w1c_clear: got %h want 0000", d); else n_pass++;
    bus_write(2'd2, 16'h0001);
  endtask

  task automatic test_reset_mid_service();
    logic [15:0] d;
    bus_write(2'd1, 16'h0001);
    irq_src = 4'b0001; tick(); irq_src = '0;
    tick();
    pulse_ack();
    bus_read(2'd3, d);
    n_checks++; if (d !== 16'h8000) $display("FAIL rst_svc_status: got %h want 8000", d); else n_pass++;
    rst = 1'b1; tick(); rst = 1'b0;
    n_checks++; if (int_req !== 1'b0) $display("FAIL rst_svc_req: got %b want 0", int_req); else n_pass++;
    n_checks++; if (rdata !== 16'h0) $display("FAIL rst_svc_rdata: got %h want 0000", rdata); else n_pass++;
    n_checks++; if (int_vector !== 16'h0) $display("FAIL rst_svc_vec: got %h want 0000", int_vector); else n_pass++;
    pulse_done();
    tick();
    n_checks++; if (int_req !== 1'b0) $display("FAIL rst_svc_done: got %b want 0", int_req); else n_pass++;
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), d);
      n_checks++; if (d !== 16'h0) $display("FAIL rst_svc_reg%0d: got %h want 0000", a, d); else n_pass++;
    end
  endtask

  // Randomized traffic against a behavioural model of the controller.
  task automatic test_random();
    int unsigned m_pend, m_mask, m_gie, m_irq_q, m_id, m_vec, m_rdata;
    int unsigned rises, clr, gie_n, mask_n, ack_bit, pend_n, elig, rd;
    int          m_phase, phase_n; // 0 idle, 1 requesting, 2 in service
    logic        wr, rdv;
    rst = 1'b1; tick(); rst = 1'b0;
    bus_write(2'd1, 16'h000F);
    bus_write(2'd2, 16'h0001);
    m_pend = 0; m_mask = 'hF; m_gie = 1; m_irq_q = 0; m_id = 0; m_vec = 0;
    m_rdata = 0; m_phase = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if ($urandom % 4 == 0) irq_src = 4'($urandom);
      case ($urandom % 8)
        0:       begin sel = 1; write = 1; read = 0; end
        1, 2:    begin sel = 1; write = 0; read = 1; end
        default: begin sel = 0; write = 0; read = 0; end
      endcase
      addr     = 2'($urandom);
      wdata    = 16'($urandom);
      int_ack  = ($urandom % 3 == 0);
      int_done = ($urandom % 4 == 0);

      wr  = sel && write;
      rdv = sel && read;
      case (addr)
        2'd0:    rd = m_pend;
        2'd1:    rd = m_mask;
        2'd2:    rd = m_gie;
        default: rd = ((m_phase == 2) ? 32'h8000 : 0) | ((m_phase == 1) ? 32'h4000 : 0) | m_id;
      endcase
      rises   = int'(irq_src) & ~m_irq_q & 'hF;
      clr     = (wr && addr == 2'd0) ? (int'(wdata) & 'hF) : 0;
      gie_n   = (wr && addr == 2'd2) ? (int'(wdata) & 1) : m_gie;
      mask_n  = (wr && addr == 2'd1) ? (int'(wdata) & 'hF) : m_mask;
      ack_bit = 0;
      phase_n = m_phase;
      if (m_phase == 0) begin
        elig = m_gie ? (m_pend & m_mask) : 0;
        for (int k = 3; k >= 0; k--) begin
          if ((elig >> k) & 1) begin
            m_id = k; m_vec = (16 + 4 * k) & 'hFFFF; phase_n = 1;
          end
        end
      end else if (m_phase == 1 && int_ack) begin
        ack_bit = 1 << m_id;
        phase_n = 2;
      end else if (m_phase == 2 && int_done) begin
        phase_n = 0;
      end
      pend_n = ((m_pend & ~clr & ~ack_bit) | rises) & 'hF;
      if (m_phase == 1 && !int_ack && (gie_n == 0 || ((pend_n >> m_id) & 1) == 0)) phase_n = 0;
      m_pend = pend_n; m_mask = mask_n; m_gie = gie_n; m_phase = phase_n;
      m_irq_q = int'(irq_src);
      if (rdv) m_rdata = rd;

      tick();
      n_checks++; if (int_req !== (m_phase == 1)) $display("FAIL rand_req@%0d: got %b want %b", cyc, int_req, m_phase == 1); else n_pass++;
      n_checks++; if (int_vector !== 16'(m_vec)) $display("FAIL rand_vec@%0d: got %h want %h", cyc, int_vector, 16'(m_vec)); else n_pass++;
      n_checks++; if (active_id !== 4'(m_id)) $display("FAIL rand_id@%0d: got %0d want %0d", cyc, active_id, m_id); else n_pass++;
      n_checks++; if (rdata !== 16'(m_rdata)) $display("FAIL rand_rdata@%0d: got %h want %h", cyc, rdata, 16'(m_rdata)); else n_pass++;
    end
    sel = 0; write = 0; read = 0; int_ack = 0; int_done = 0; irq_src = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_masking();
    test_withdraw();
    test_level_w1c();
    test_reset_mid_service();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/int_controller.md
Name: int_controller

Overview:
- Prioritised interrupt controller between the io_bridge peripherals (keyboard, LCD, timer, ...) and the cpu interrupt entry.
- Captures rising edges from up to NUM_SRC request lines and holds them pending until cleared.
- Applies a per-source mask and a global enable, then presents one request at a time to the cpu with a vector address.
- Sequences the request/acknowledge/return handshake; no nesting.
- Register file is memory-mapped through the io_bridge address decode.

Parameters:
NUM_SRC, 4, number of interrupt sources (1..15)
VEC_BASE, 16'h0010, vector address of source 0
VEC_STRIDE, 16'h0004, address distance between consecutive source vectors

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
irq_src  in  NUM_SRC  peripheral request lines, level, synchronous to clk
sel  in  1  register access strobe from io_bridge decode
addr  in  2  register index
write  in  1  write strobe, qualified by sel
read  in  1  read strobe, qualified by sel
wdata  in  16  write data
rdata  out  16  read data, registered
int_req  out  1  interrupt request to cpu
int_vector  out  16  vector address of the requested source, valid while int_req=1
int_ack  in  1  cpu accepts the request; single-cycle pulse
int_done  in  1  cpu returns from handler; single-cycle pulse
active_id  out  4  index of the source in REQ or SERVICE state

Behaviour:
- Reset (clk edge with rst=1): int_req=0, int_vector=0, rdata=0, active_id=0. Pending, mask, enable and edge-history registers all 0. FSM goes to IDLE. Reset mid-handshake abandons the handshake with no further outputs.
- Edge capture: irq_q <= irq_src each cycle. pending[i] sets on the edge where irq_src[i]=1 and irq_q[i]=0. A held-high level produces exactly one set.
- Registers:
  - addr 0 PENDING: read returns pending; write-1-to-clear.
  - addr 1 MASK: read/write; bit=1 enables the source.
  - addr 2 CTRL: bit0 GIE; other bits read 0.
  - addr 3 STATUS: read-only; bit15=in_service, bit14=int_req, bits3:0=active_id.
  - Bits at or above NUM_SRC read 0. Writes to STATUS are ignored.
- rdata is updated one cycle after a cycle with sel&read, and holds its value otherwise.
- Same-cycle W1C and new edge on the same bit: set wins, so the bit stays 1.
- eligible = pending & mask, gated by GIE. Priority is fixed: the lowest index wins.
- FSM:
  - IDLE: if eligible is nonzero, latch the winner into active_id, set int_vector = VEC_BASE + id*VEC_STRIDE (16-bit wrap), and go to REQ. int_req=1 from the next cycle.
  - REQ: int_req=1 and int_vector is stable.
    - On int_ack: clear pending[active_id] in the same edge, int_req=0, go to SERVICE.
    - If GIE is cleared, or pending[active_id] is cleared by W1C, before the ack: int_req=0, go to IDLE. Pending bits stay as they are, except any bit cleared by the W1C.
    - Mask changes during REQ do not withdraw the request.
    - A higher-priority edge during REQ does not preempt.
  - SERVICE: int_req=0; new edges keep accumulating in pending. On int_done, go to IDLE. Re-arbitration happens in IDLE, so the next int_req rises 2 cycles after int_done at the earliest.
  - int_ack outside REQ and int_done outside SERVICE are ignored.
  - int_ack and GIE-clear in the same cycle: the ack wins.
- Latency: irq_src rises at edge n, so pending=1 after edge n and int_req=1 after edge n+1 (2 cycles), provided the source is unmasked, GIE=1 and the FSM is in IDLE.

Test Plan:
- Basic flow: MASK=0x0001, CTRL=1, pulse irq_src[0] -> int_req=1 two cycles later, int_vector=0x0010. Pulse int_ack -> int_req=0 and PENDING reads 0. Pulse int_done -> STATUS bit15 goes 0.
- Priority: MASK=0xF, GIE=1, irq_src[3] and irq_src[1] rise in the same cycle -> active_id=1 and int_vector=0x0014. After ack and done -> second request with active_id=3 and int_vector=0x001C.
- Masking: MASK=0, edge on src2 -> PENDING=0x0004 and no int_req. Write MASK=0x4 -> int_req within 1 cycle, vector=0x0018.
- Withdraw: in REQ for src0, write CTRL=0 -> int_req=0 next cycle and PENDING still 0x0001. Write CTRL=1 -> request re-issued.
- Level held and W1C race: hold irq_src[0]=1 for 10 cycles -> exactly one pending set. W1C of bit 1 issued in the same cycle as the src1 edge -> PENDING bit1 reads 1.
- Reset mid-SERVICE: assert rst for 1 cycle -> int_req=0, all registers read 0, and a following int_done is ignored.
